// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, registered-read, big-endian RAM between the
// fetch port and the data port, adding byte loads and read-modify-write byte stores.
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic             dm_byte,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [WIDTH-1:0] dm_rdata,
  output logic [WIDTH-1:0] ram_ad,
  output logic [WIDTH-1:0] ram_d,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    MERGE  = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       last_dm_r;
  logic       own_dm_r;
  logic       we_r;
  logic       byte_r;
  logic [7:0] wbyte_r;

  // Arbitration; gated by nrst so nothing is granted while reset is held
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (nrst && (state_r == IDLE)) begin
      if (if_req && dm_req) begin
        if ((FIXED_PRIO != 0) || !last_dm_r) begin
          dm_gnt = 1'b1;
        end else begin
          if_gnt = 1'b1;
        end
      end else begin
        if_gnt = if_req;
        dm_gnt = dm_req;
      end
    end else begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (if_gnt || dm_gnt) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (own_dm_r && we_r && byte_r) begin
          state_nxt_s = MERGE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      MERGE:   state_nxt_s = WRITE;
      WRITE:   state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch and RAM control; only the store byte is kept for the merge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ram_ad    <= {WIDTH{1'b0}};
      ram_d     <= {WIDTH{1'b0}};
      ram_we    <= 1'b0;
      last_dm_r <= 1'b0;
      own_dm_r  <= 1'b0;
      we_r      <= 1'b0;
      byte_r    <= 1'b0;
      wbyte_r   <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (dm_gnt) begin
            ram_ad    <= dm_addr;
            ram_d     <= dm_wdata;
            ram_we    <= dm_we & ~dm_byte;
            last_dm_r <= 1'b1;
            own_dm_r  <= 1'b1;
            we_r      <= dm_we;
            byte_r    <= dm_byte;
            wbyte_r   <= dm_wdata[7:0];
          end else if (if_gnt) begin
            ram_ad    <= if_addr;
            ram_d     <= dm_wdata;
            ram_we    <= 1'b0;
            last_dm_r <= 1'b0;
            own_dm_r  <= 1'b0;
            we_r      <= 1'b0;
            byte_r    <= 1'b0;
          end else begin
            ram_we <= 1'b0;
          end
        end
        // The addressed byte is the most significant one of the big-endian word
        MERGE: begin
          ram_d  <= {wbyte_r, ram_q[WIDTH-9:0]};
          ram_we <= 1'b1;
        end
        default: ram_we <= 1'b0;
      endcase
    end
  end

  // Response to the owning port during RESP; data is zero outside rvalid
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = {WIDTH{1'b0}};
    dm_rvalid = 1'b0;
    dm_rdata  = {WIDTH{1'b0}};
    if (state_r == RESP) begin
      if (own_dm_r) begin
        dm_rvalid = 1'b1;
        if (we_r) begin
          dm_rdata = {WIDTH{1'b0}};
        end else if (byte_r) begin
          dm_rdata = {{(WIDTH-8){1'b0}}, ram_q[WIDTH-1:WIDTH-8]};
        end else begin
          dm_rdata = ram_q;
        end
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = ram_q;
      end
    end else begin
      if_rvalid = 1'b0;
      dm_rvalid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: a round-robin instance on a byte-array
// RAM model and a fixed-priority instance on a simple address-derived RAM.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        if_req, dm_req, dm_we, dm_byte;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, ram_we;
  logic [31:0] if_rdata, dm_rdata, ram_ad, ram_d, ram_q;

  logic        fp_if_req, fp_dm_req, fp_dm_we, fp_dm_byte;
  logic [31:0] fp_if_addr, fp_dm_addr, fp_dm_wdata;
  logic        fp_if_gnt, fp_if_rvalid, fp_dm_gnt, fp_dm_rvalid, fp_ram_we;
  logic [31:0] fp_if_rdata, fp_dm_rdata, fp_ram_ad, fp_ram_d, fp_ram_q;

  logic [7:0]  mem [0:255];
  int          check_cnt = 0;
  int          pass_cnt  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .nrst(nrst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ram_ad(ram_ad), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  mem_port_arbiter #(.WIDTH(32), .FIXED_PRIO(1)) u_dut_fp (
    .clk(clk), .nrst(nrst),
    .if_req(fp_if_req), .if_addr(fp_if_addr), .if_gnt(fp_if_gnt), .if_rvalid(fp_if_rvalid),
    .if_rdata(fp_if_rdata),
    .dm_req(fp_dm_req), .dm_we(fp_dm_we), .dm_byte(fp_dm_byte), .dm_addr(fp_dm_addr),
    .dm_wdata(fp_dm_wdata), .dm_gnt(fp_dm_gnt), .dm_rvalid(fp_dm_rvalid), .dm_rdata(fp_dm_rdata),
    .ram_ad(fp_ram_ad), .ram_d(fp_ram_d), .ram_we(fp_ram_we), .ram_q(fp_ram_q)
  );

  // Byte-addressed big-endian RAM with registered read (old data on read-during-write)
  always @(posedge clk) begin
    ram_q <= {mem[8'(ram_ad)], mem[8'(ram_ad + 32'd1)], mem[8'(ram_ad + 32'd2)], mem[8'(ram_ad + 32'd3)]};
    if (ram_we) begin
      for (int k = 0; k < 4; k++) mem[8'(ram_ad + 32'(k))] = ram_d[31-8*k -: 8];
    end
  end

  always @(posedge clk) fp_ram_q <= fp_ram_ad ^ 32'hA5A5_0000;

  task automatic test_reset;
    nrst = 1'b1;
    #2 nrst = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0;
    if_addr = 32'h10; dm_addr = 32'h10; dm_wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_cnt++; if ({if_gnt, dm_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b want 00", {if_gnt, dm_gnt}); else pass_cnt++;
    check_cnt++; if ({ram_we, if_rvalid, dm_rvalid} !== 3'b000) $display("FAIL rst_we_rvalid: got %b want 000", {ram_we, if_rvalid, dm_rvalid}); else pass_cnt++;
    check_cnt++; if ((ram_ad | ram_d | if_rdata | dm_rdata) !== 32'h0) $display("FAIL rst_data: got ad=%h d=%h want 0", ram_ad, ram_d); else pass_cnt++;
    @(negedge clk); nrst = 1'b1; #1;
    check_cnt++; if ({if_gnt, dm_gnt} !== 2'b01) $display("FAIL rst_first_dm: got if/dm=%b want 01", {if_gnt, dm_gnt}); else pass_cnt++;
    @(negedge clk); dm_req = 1'b0; #1;
    check_cnt++; if ({if_gnt, dm_rvalid, ram_ad} !== {2'b00, 32'h10}) $display("FAIL rst_access: got gnt=%b rv=%b ad=%h", if_gnt, dm_rvalid, ram_ad); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if ({dm_rvalid, if_rvalid, dm_rdata} !== {2'b10, 32'h11223344}) $display("FAIL rst_load: got rv=%b%b rdata=%h want 10 11223344", dm_rvalid, if_rvalid, dm_rdata); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if (if_gnt !== 1'b1) $display("FAIL pending_if_gnt: got %b want 1", if_gnt); else pass_cnt++;
    @(negedge clk); if_req = 1'b0; #1;
    @(negedge clk); #1;
    check_cnt++; if ({if_rvalid, dm_rvalid, if_rdata} !== {2'b10, 32'h11223344}) $display("FAIL pending_if_data: got rv=%b%b rdata=%h", if_rvalid, dm_rvalid, if_rdata); else pass_cnt++;
    @(negedge clk); #1;
  endtask

  task automatic test_fetch;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h10; #1;
    check_cnt++; if ({if_gnt, dm_gnt} !== 2'b10) $display("FAIL fetch_gnt: got %b want 10", {if_gnt, dm_gnt}); else pass_cnt++;
    @(negedge clk); if_req = 1'b0; if_addr = 32'hFFFF_FFFF; #1;
    check_cnt++; if ({if_gnt, if_rvalid} !== 2'b00) $display("FAIL fetch_t1: got gnt/rv=%b want 00", {if_gnt, if_rvalid}); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if ({if_rvalid, dm_rvalid, if_rdata} !== {2'b10, 32'h11223344}) $display("FAIL fetch_data: got rv=%b%b rdata=%h want 10 11223344", if_rvalid, dm_rvalid, if_rdata); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h0}) $display("FAIL fetch_pulse: got rv=%b rdata=%h want 0 0", if_rvalid, if_rdata); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    logic exp_dm;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'h21;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_dm = (g % 2 == 0);
      check_cnt++; if ({if_gnt, dm_gnt} !== {~exp_dm, exp_dm}) $display("FAIL rr_gnt%0d: got if/dm=%b want %b", g, {if_gnt, dm_gnt}, {~exp_dm, exp_dm}); else pass_cnt++;
      @(negedge clk); #1;
      check_cnt++; if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0000) $display("FAIL rr_busy%0d: got %b want 0000", g, {if_gnt, dm_gnt, if_rvalid, dm_rvalid}); else pass_cnt++;
      @(negedge clk);
      if (g == 3) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      #1;
      if (exp_dm) begin
        check_cnt++; if ({if_rvalid, dm_rvalid, dm_rdata} !== {2'b01, 32'h55667788}) $display("FAIL rr_resp%0d: got rv=%b%b rdata=%h", g, if_rvalid, dm_rvalid, dm_rdata); else pass_cnt++;
      end else begin
        check_cnt++; if ({if_rvalid, dm_rvalid, if_rdata} !== {2'b10, 32'h11223344}) $display("FAIL rr_resp%0d: got rv=%b%b rdata=%h", g, if_rvalid, dm_rvalid, if_rdata); else pass_cnt++;
      end
      @(negedge clk); #1;
    end
    check_cnt++; if ({if_gnt, dm_gnt} !== 2'b00) $display("FAIL rr_idle: got %b want 00", {if_gnt, dm_gnt}); else pass_cnt++;
  endtask

  task automatic test_fixed_prio;
    @(negedge clk);
    fp_if_req = 1'b1; fp_if_addr = 32'h100;
    fp_dm_req = 1'b1; fp_dm_we = 1'b0; fp_dm_byte = 1'b0; fp_dm_addr = 32'h200; fp_dm_wdata = 32'h0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check_cnt++; if ({fp_if_gnt, fp_dm_gnt} !== 2'b01) $display("FAIL fp_gnt%0d: got if/dm=%b want 01", g, {fp_if_gnt, fp_dm_gnt}); else pass_cnt++;
      @(negedge clk); #1;
      check_cnt++; if ({fp_ram_we, fp_ram_ad, fp_ram_d} !== {1'b0, 32'h200, 32'h0}) $display("FAIL fp_ram%0d: got we=%b ad=%h d=%h", g, fp_ram_we, fp_ram_ad, fp_ram_d); else pass_cnt++;
      @(negedge clk);
      if (g == 2) fp_dm_req = 1'b0;
      #1;
      check_cnt++; if ({fp_dm_rvalid, fp_if_rvalid, fp_dm_rdata} !== {2'b10, 32'hA5A50200}) $display("FAIL fp_resp%0d: got rv=%b%b rdata=%h", g, fp_dm_rvalid, fp_if_rvalid, fp_dm_rdata); else pass_cnt++;
      @(negedge clk); #1;
    end
    check_cnt++; if ({fp_if_gnt, fp_dm_gnt} !== 2'b10) $display("FAIL fp_if_late: got if/dm=%b want 10", {fp_if_gnt, fp_dm_gnt}); else pass_cnt++;
    @(negedge clk); fp_if_req = 1'b0; #1;
    @(negedge clk); #1;
    check_cnt++; if ({fp_if_rvalid, fp_if_rdata} !== {1'b1, 32'hA5A50100}) $display("FAIL fp_if_data: got rv=%b rdata=%h", fp_if_rvalid, fp_if_rdata); else pass_cnt++;
    @(negedge clk); #1;
  endtask

  task automatic test_word_store;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b0; dm_addr = 32'h40; dm_wdata = 32'hCAFEF00D;
    #1;
    check_cnt++; if (dm_gnt !== 1'b1) $display("FAIL wst_gnt: got %b want 1", dm_gnt); else pass_cnt++;
    @(negedge clk); dm_req = 1'b0; dm_wdata = 32'h0; #1;
    check_cnt++; if ({ram_we, ram_ad, ram_d} !== {1'b1, 32'h40, 32'hCAFEF00D}) $display("FAIL wst_ram: got we=%b ad=%h d=%h", ram_we, ram_ad, ram_d); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if ({dm_rvalid, ram_we, dm_rdata} !== {2'b10, 32'h0}) $display("FAIL wst_resp: got rv=%b we=%b rdata=%h", dm_rvalid, ram_we, dm_rdata); else pass_cnt++;
    check_cnt++; if ({mem[8'h40], mem[8'h43]} !== 16'hCA0D) $display("FAIL wst_mem: got %h want CA0D", {mem[8'h40], mem[8'h43]}); else pass_cnt++;
    @(negedge clk); #1;
  endtask

  task automatic test_byte_store;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b1; dm_addr = 32'h21; dm_wdata = 32'hDEADBEAB;
    #1;
    check_cnt++; if (dm_gnt !== 1'b1) $display("FAIL bst_gnt: got %b want 1", dm_gnt); else pass_cnt++;
    @(negedge clk); dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0; dm_wdata = 32'h0; #1;
    check_cnt++; if ({ram_we, dm_rvalid} !== 2'b00) $display("FAIL bst_access: got we/rv=%b want 00", {ram_we, dm_rvalid}); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if ({ram_we, dm_rvalid} !== 2'b00) $display("FAIL bst_merge: got we/rv=%b want 00", {ram_we, dm_rvalid}); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if ({ram_we, dm_rvalid, ram_ad, ram_d} !== {2'b10, 32'h21, 32'hAB667788}) $display("FAIL bst_write: got we=%b rv=%b ad=%h d=%h", ram_we, dm_rvalid, ram_ad, ram_d); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if ({dm_rvalid, ram_we, dm_rdata} !== {2'b10, 32'h0}) $display("FAIL bst_resp: got rv=%b we=%b rdata=%h", dm_rvalid, ram_we, dm_rdata); else pass_cnt++;
    @(negedge clk); #1;
    check_cnt++; if ({mem[8'h21], mem[8'h25]} !== 16'hAB99) $display("FAIL bst_mem: got %h want AB99", {mem[8'h21], mem[8'h25]}); else pass_cnt++;
    dm_req = 1'b1; dm_addr = 32'h21; #1;
    @(negedge clk); dm_req = 1'b0; #1;
    @(negedge clk); #1;
    check_cnt++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'hAB667788}) $display("FAIL bst_readback: got rv=%b rdata=%h want 1 AB667788", dm_rvalid, dm_rdata); else pass_cnt++;
    @(negedge clk); #1;
  endtask

  task automatic test_byte_load;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b1; dm_addr = 32'h23; #1;
    check_cnt++; if (dm_gnt !== 1'b1) $display("FAIL bld_gnt: got %b want 1", dm_gnt); else pass_cnt++;
    @(negedge clk); dm_req = 1'b0; #1;
    @(negedge clk); #1;
    check_cnt++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h00000077}) $display("FAIL bld_data: got rv=%b rdata=%h want 1 00000077", dm_rvalid, dm_rdata); else pass_cnt++;
    @(negedge clk); #1;
  endtask

  task automatic test_reset_merge;
    logic seen_we = 1'b0;
    logic seen_rv = 1'b0;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b1; dm_addr = 32'h21; dm_wdata = 32'h3C; #1;
    check_cnt++; if (dm_gnt !== 1'b1) $display("FAIL rmg_gnt: got %b want 1", dm_gnt); else pass_cnt++;
    @(negedge clk); dm_req = 1'b0; #1;
    @(negedge clk); nrst = 1'b0; #1;
    check_cnt++; if ({ram_we, ram_ad} !== {1'b0, 32'h0}) $display("FAIL rmg_async: got we=%b ad=%h want 0 0", ram_we, ram_ad); else pass_cnt++;
    #2 nrst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (ram_we) seen_we = 1'b1;
      if (dm_rvalid) seen_rv = 1'b1;
    end
    check_cnt++; if ({seen_we, seen_rv} !== 2'b00) $display("FAIL rmg_quiet: got we/rv seen=%b want 00", {seen_we, seen_rv}); else pass_cnt++;
    check_cnt++; if (mem[8'h21] !== 8'hAB) $display("FAIL rmg_mem: got %h want AB", mem[8'h21]); else pass_cnt++;
    dm_we = 1'b0; dm_req = 1'b1; #1;
    check_cnt++; if (dm_gnt !== 1'b1) $display("FAIL rmg_next_gnt: got %b want 1", dm_gnt); else pass_cnt++;
    @(negedge clk); dm_req = 1'b0; #1;
    @(negedge clk); #1;
    check_cnt++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h000000AB}) $display("FAIL rmg_next_data: got rv=%b rdata=%h want 1 000000AB", dm_rvalid, dm_rdata); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} = 32'h11223344;
    {mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24], mem[8'h25]} = 40'h5566778899;
    fp_if_req = 1'b0; fp_dm_req = 1'b0; fp_dm_we = 1'b0; fp_dm_byte = 1'b0;
    fp_if_addr = 32'h0; fp_dm_addr = 32'h0; fp_dm_wdata = 32'h0;
    test_reset();
    test_fetch();
    test_round_robin();
    test_fixed_prio();
    test_word_store();
    test_byte_store();
    test_byte_load();
    test_reset_merge();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sole controller of the single-port, byte-addressed, big-endian, word-wide block RAM. The RAM has a registered read, so q is valid one cycle after ad is presented.
- Shares the RAM between the instruction-fetch port (if_*) and the data-memory port (dm_*).
- Adds byte loads and stores (ldrb/strb) on top of the word-only RAM; byte stores are done as an internal read-modify-write.
- Sits between the CPU fetch/memory stages and the RAM instance.

Parameters:
WIDTH, 32, word width in bits (4 bytes of 8 bits).
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = dm always wins a simultaneous request.

Ports:
clk  input  1  clock; all state updates on posedge.
nrst  input  1  asynchronous active-low reset.
if_req  input  1  fetch read request; held stable until if_gnt.
if_addr  input  WIDTH  fetch byte address.
if_gnt  output  1  request accepted this cycle; combinational.
if_rvalid  output  1  one-cycle pulse: if_rdata valid.
if_rdata  output  WIDTH  fetched word.
dm_req  input  1  data request; held stable until dm_gnt.
dm_we  input  1  1 = store, 0 = load.
dm_byte  input  1  1 = byte access, 0 = word access.
dm_addr  input  WIDTH  data byte address; unaligned addresses are allowed.
dm_wdata  input  WIDTH  store data; byte stores use dm_wdata[7:0].
dm_gnt  output  1  request accepted this cycle; combinational.
dm_rvalid  output  1  one-cycle completion pulse, for loads and stores.
dm_rdata  output  WIDTH  load data; byte loads are zero-extended.
ram_ad  output  WIDTH  RAM address; registered.
ram_d  output  WIDTH  RAM write data; registered.
ram_we  output  1  RAM write enable; registered.
ram_q  input  WIDTH  RAM read data; valid one cycle after ram_ad.

Behaviour:
- States: IDLE, ACCESS, MERGE, WRITE, RESP. Reset state is IDLE.
- Reset values: ram_ad = 0, ram_d = 0, ram_we = 0, gnt = 0, rvalid = 0, rdata = 0, round-robin pointer last = IF.
- Arbitration (IDLE only; gnt is low in every other state):
  - One requester: that requester is granted.
  - Both, FIXED_PRIO = 0: grant the port not granted last, then update last.
  - Both, FIXED_PRIO = 1: grant dm.
  - The granted gnt is high for exactly one cycle.
  - On that edge the block latches address, we, byte and wdata. The requester may change its inputs the next cycle.
- Grant edge actions:
  - ram_ad <= granted address.
  - ram_d <= dm_wdata.
  - ram_we <= 1 only for a dm word store; else 0.
  - State -> ACCESS.
- ACCESS:
  - Word store: the write happens at the end of this cycle; ram_we <= 0; -> RESP.
  - Loads, fetches and byte stores: the RAM read happens; -> RESP for loads/fetches, -> MERGE for byte stores.
- MERGE (byte store): ram_d <= {latched wdata[7:0], ram_q[WIDTH-9:0]}; ram_we <= 1; -> WRITE.
  - Big-endian: the byte at ram_ad is ram_q[31:24].
- WRITE: the write commits at the end of the cycle; ram_we <= 0; -> RESP.
- RESP: rvalid = 1 on the owning port for one cycle; -> IDLE.
  - Word load/fetch: rdata = ram_q.
  - Byte load: rdata = {24'b0, ram_q[31:24]}.
  - Store: rdata = 0.
  - rdata is 0 whenever rvalid is low.
- Latency, counting grant cycle = T:
  - Fetch, word load, word store: rvalid at T+2.
  - Byte load: rvalid at T+2.
  - Byte store: rvalid at T+4.
- Throughput: at most one transaction per 3 cycles (5 for a byte store). A new grant is possible only in the IDLE cycle after RESP.
- The other port's request is never lost: it stays pending and is granted in the next IDLE.
- Address wrap-around is the RAM's concern; addresses pass through unmodified.
- The non-owning port sees gnt = 0 and rvalid = 0 throughout a transaction.
- Reset mid-operation:
  - Asynchronous return to IDLE; ram_we drops immediately.
  - The in-flight transaction is dropped and no rvalid is issued.
  - A byte store reset before WRITE never writes.

Test Plan:
- Reset: hold nrst low with both reqs high -> gnt = 0, ram_we = 0, rvalid = 0 and all outputs 0. After release, the first simultaneous request grants dm.
- Fetch: RAM[0x10..0x13] = 11 22 33 44; if_req with addr 0x10 -> if_gnt at T, if_rvalid at T+2, if_rdata = 0x11223344, dm_rvalid = 0.
- Round-robin (FIXED_PRIO = 0): both requesting continuously -> grants alternate dm, if, dm, if, 3 cycles apart, each rvalid on the correct port. With FIXED_PRIO = 1 -> dm granted every time.
- Byte store:
  - Setup: RAM[0x21..0x24] = 55 66 77 88; dm byte store 0xAB at 0x21.
  - Expect: ram_we high only in ACCESS-free WRITE cycle, ram_d = 0xAB667788, dm_rvalid at T+4.
  - Read back word at 0x21 = 0xAB667788; RAM[0x25] unchanged.
- Byte load at 0x23 of the above -> dm_rdata = 0x00000077 at T+2.
- Reset pulse during the MERGE cycle of a byte store -> ram_we never asserted, no dm_rvalid, RAM[0x21] unchanged, next request served normally.
